// File: rtl/uart_axil_arb_pkg.sv
// Shared types and constants for the UART AXI4-Lite requester arbiter.
package uart_axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

  // Width of a counter that must hold 0 .. limit-1.
  function automatic int to_cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after rr_ptr,
// wrapping modulo NUM_REQ. grant is one-hot, valid says whether anything won.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  // Scan offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((i == idx) && !valid && req[i]) begin
          grant[i] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_axil_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite UART slave port between NUM_REQ
// requesters, one transaction in flight at a time.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to add a per-state watchdog
// that completes a stalled transaction with SLVERR and exposes a sticky
// timeout_o flag.
//
// Handshake semantics: every channel is valid/ready; a beat transfers on a
// cycle where both are high, valid never depends on ready, and a requester
// holds valid and payload stable until its beat transfers. Non-granted
// requesters see every ready and valid at 0.
module uart_axil_arbiter
  import uart_axil_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int ADDR_W      = 13,
  parameter  int DATA_W      = 32,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int PTR_W       = $clog2(NUM_REQ),
  localparam int STRB_W      = DATA_W / 8
) (
  input  logic                            chipset_clk,
  input  logic                            chipset_rst_n,
  // requester side
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  s_awaddr,
  input  logic [NUM_REQ-1:0]              s_awvalid,
  output logic [NUM_REQ-1:0]              s_awready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  s_wdata,
  input  logic [NUM_REQ-1:0][STRB_W-1:0]  s_wstrb,
  input  logic [NUM_REQ-1:0]              s_wvalid,
  output logic [NUM_REQ-1:0]              s_wready,
  output logic [NUM_REQ-1:0][1:0]         s_bresp,
  output logic [NUM_REQ-1:0]              s_bvalid,
  input  logic [NUM_REQ-1:0]              s_bready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  s_araddr,
  input  logic [NUM_REQ-1:0]              s_arvalid,
  output logic [NUM_REQ-1:0]              s_arready,
  output logic [NUM_REQ-1:0][DATA_W-1:0]  s_rdata,
  output logic [NUM_REQ-1:0][1:0]         s_rresp,
  output logic [NUM_REQ-1:0]              s_rvalid,
  input  logic [NUM_REQ-1:0]              s_rready,
  // downstream UART slave port
  output logic [ADDR_W-1:0]               uart_axi_awaddr,
  output logic                            uart_axi_awvalid,
  input  logic                            uart_axi_awready,
  output logic [DATA_W-1:0]               uart_axi_wdata,
  output logic [STRB_W-1:0]               uart_axi_wstrb,
  output logic                            uart_axi_wvalid,
  input  logic                            uart_axi_wready,
  input  logic [1:0]                      uart_axi_bresp,
  input  logic                            uart_axi_bvalid,
  output logic                            uart_axi_bready,
  output logic [ADDR_W-1:0]               uart_axi_araddr,
  output logic                            uart_axi_arvalid,
  input  logic                            uart_axi_arready,
  input  logic [DATA_W-1:0]               uart_axi_rdata,
  input  logic [1:0]                      uart_axi_rresp,
  input  logic                            uart_axi_rvalid,
  output logic                            uart_axi_rready,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                            timeout_o,
`endif
  output logic [NUM_REQ-1:0]              grant_o,
  // debug visibility of the FSM
  output state_e                          dbg_state,
  output logic [PTR_W-1:0]                dbg_rr_ptr
);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q;
  logic [PTR_W-1:0]     g_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic                 aw_done_q, w_done_q;
  logic                 err_q;
  logic                 to_hit;

  logic [NUM_REQ-1:0]   req, wr_req;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 arb_valid;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_is_wr;

  logic                 aw_hs, w_hs, ar_hs;
  logic                 wr_resp_done, rd_resp_done;

  // A write needs both AW and W presented; a lone AW or W is ignored.
  assign wr_req    = s_awvalid & s_wvalid;
  assign req       = wr_req | s_arvalid;
  assign arb_is_wr = |(arb_grant & wr_req);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  // One-hot winner to index for muxing.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) arb_idx = PTR_W'(i);
    end
  end

  // Beat completions on the downstream port for the granted requester.
  assign aw_hs = (state_q == WR_ADDR) && !aw_done_q && !to_hit &&
                 s_awvalid[g_q] && uart_axi_awready;
  assign w_hs  = (state_q == WR_ADDR) && !w_done_q && !to_hit &&
                 s_wvalid[g_q] && uart_axi_wready;
  assign ar_hs = (state_q == RD_ADDR) && !to_hit &&
                 s_arvalid[g_q] && uart_axi_arready;

  // After a watchdog expiry the error response is ours, so only the requester gates it.
  assign wr_resp_done = s_bready[g_q] && (err_q || uart_axi_bvalid);
  assign rd_resp_done = s_rready[g_q] && (err_q || uart_axi_rvalid);

  // FSM state register.
  always_ff @(posedge chipset_clk) begin
    if (!chipset_rst_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) state_d = arb_is_wr ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: begin
        if (to_hit || ((aw_done_q || aw_hs) && (w_done_q || w_hs))) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (wr_resp_done) state_d = IDLE;
      end
      RD_ADDR: begin
        if (ar_hs || to_hit) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rd_resp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, pointer and write-progress bookkeeping.
  always_ff @(posedge chipset_clk) begin
    if (!chipset_rst_n) begin
      grant_q   <= '0;
      g_q       <= '0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (arb_valid) begin
          grant_q <= arb_grant;
          g_q     <= arb_idx;
        end
      end else begin
        if (aw_hs || (to_hit && state_q == WR_ADDR)) aw_done_q <= 1'b1;
        if (w_hs  || (to_hit && state_q == WR_ADDR)) w_done_q  <= 1'b1;
        if (state_d == IDLE) begin
          grant_q  <= '0;
          rr_ptr_q <= (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + PTR_W'(1);
        end
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = to_cnt_w(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  assign to_hit    = (state_q != IDLE) && !err_q && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_o = timeout_q;

  // Watchdog: restarts on every state entry, freezes once the error path is taken.
  always_ff @(posedge chipset_clk) begin
    if (!chipset_rst_n) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) || (state_d != state_q)) cnt_q <= '0;
      else if (!err_q)                                cnt_q <= cnt_q + CNT_W'(1);
      if (state_d == IDLE) err_q <= 1'b0;
      else if (to_hit)     err_q <= 1'b1;
      if (to_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err_q  = 1'b0;
`endif

  // Output mux from registered state and grant; everything idles at 0.
  always_comb begin
    s_awready        = '0;
    s_wready         = '0;
    s_bresp          = '0;
    s_bvalid         = '0;
    s_arready        = '0;
    s_rdata          = '0;
    s_rresp          = '0;
    s_rvalid         = '0;
    uart_axi_awaddr  = '0;
    uart_axi_awvalid = 1'b0;
    uart_axi_wdata   = '0;
    uart_axi_wstrb   = '0;
    uart_axi_wvalid  = 1'b0;
    uart_axi_bready  = 1'b0;
    uart_axi_araddr  = '0;
    uart_axi_arvalid = 1'b0;
    uart_axi_rready  = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
        // Swallow responses that arrive after a watchdog abort.
        uart_axi_bready = 1'b1;
        uart_axi_rready = 1'b1;
`endif
      end
      WR_ADDR: begin
        uart_axi_awaddr  = s_awaddr[g_q];
        uart_axi_awvalid = s_awvalid[g_q] && !aw_done_q && !to_hit;
        uart_axi_wdata   = s_wdata[g_q];
        uart_axi_wstrb   = s_wstrb[g_q];
        uart_axi_wvalid  = s_wvalid[g_q] && !w_done_q && !to_hit;
        s_awready[g_q]   = !aw_done_q && (uart_axi_awready || to_hit);
        s_wready[g_q]    = !w_done_q && (uart_axi_wready || to_hit);
      end
      WR_RESP: begin
        if (err_q) begin
          s_bvalid[g_q] = 1'b1;
          s_bresp[g_q]  = RESP_SLVERR;
        end else begin
          uart_axi_bready = s_bready[g_q];
          s_bvalid[g_q]   = uart_axi_bvalid;
          s_bresp[g_q]    = uart_axi_bresp;
        end
      end
      RD_ADDR: begin
        uart_axi_araddr  = s_araddr[g_q];
        uart_axi_arvalid = s_arvalid[g_q] && !to_hit;
        s_arready[g_q]   = uart_axi_arready || to_hit;
      end
      RD_DATA: begin
        if (err_q) begin
          s_rvalid[g_q] = 1'b1;
          s_rresp[g_q]  = RESP_SLVERR;
          s_rdata[g_q]  = DATA_W'(ERR_RDATA);
        end else begin
          uart_axi_rready = s_rready[g_q];
          s_rvalid[g_q]   = uart_axi_rvalid;
          s_rresp[g_q]    = uart_axi_rresp;
          s_rdata[g_q]    = uart_axi_rdata;
        end
      end
      default: ;
    endcase
  end

  assign grant_o    = grant_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule
